regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined LC-3b datapath. Successor to the fixed 8x16 file.
- Adds a per-register busy scoreboard, used by decode for RAW hazard stalls.
- Adds a post-reset sequential zeroing sweep with a ready flag, so no power-on initial values are needed.
- Two combinational read ports and one synchronous write port. Sits between decode (src/dest, alloc) and writeback (load).

Parameters:
- WIDTH, 16, data word width in bits.
- NREGS, 8, number of registers; power of 2, >= 2.
- AW, $clog2(NREGS), register address width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ready  output  1  high once the init sweep completes
- load  input  1  writeback write enable
- dest  input  AW  writeback register index
- in  input  WIDTH  writeback data
- alloc  input  1  decode: mark alloc_reg busy (pending writer issued)
- alloc_reg  input  AW  register to mark busy
- src_a  input  AW  read port A index
- src_b  input  AW  read port B index
- reg_a  output  WIDTH  read data A
- reg_b  output  WIDTH  read data B
- busy_a  output  1  scoreboard bit of src_a
- busy_b  output  1  scoreboard bit of src_b
- any_busy  output  1  OR of all busy bits
- alloc_err  output  1  sticky: alloc hit an already-busy register

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset, rst_n low, asynchronous:
  - state=INIT, init_ptr=0, busy[]=0, alloc_err=0, ready=0.
  - Storage array is not async-reset; the sweep clears it.
- INIT:
  - Each cycle writes data[init_ptr]=0 and increments init_ptr.
  - When init_ptr==NREGS-1 is written, go to RUN next edge.
  - ready rises exactly NREGS clocks after rst_n deasserts (8 for the default).
  - load and alloc are ignored. reg_a, reg_b, busy_a, busy_b, any_busy read 0.
- RUN: ready=1 and stays 1 until the next reset. No other state transitions.
- Write, RUN, load=1:
  - data[dest]<=in and busy[dest]<=0 at the clock edge.
  - Load to a non-busy register is legal: write occurs, busy stays 0, no error.
- Alloc, RUN, alloc=1:
  - busy[alloc_reg]<=1.
  - If busy[alloc_reg] is already 1, alloc_err<=1 (sticky until reset); busy stays 1.
- Simultaneous load and alloc on the same index: alloc wins. Data is written, busy ends 1 (a new writer is pending). alloc_err is not set, because the old writer retires the same cycle.
- Simultaneous load and alloc on different indices: both take effect.
- Reads are combinational and zero-latency: reg_a=data[src_a], busy_a=busy[src_a]; port B likewise. src_a==src_b is legal and both ports return the same value.
- Widths: all indices are AW bits, so no out-of-range index exists and there is no wrap logic.
- Reset mid-sweep or mid-RUN: returns to INIT immediately. Pending busy bits are discarded and the sweep restarts from index 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, when load=1 and dest==src_a, reg_a=in and busy_a=0 in the same cycle (write-through forwarding); port B likewise. If alloc targets the same index that cycle, busy_a still shows 1, because alloc wins.
- Undefined: read ports show the pre-edge stored value and busy bit; the new value is visible the cycle after the write.

Test Plan:
- Release rst_n; pulse load dest=3 in=16'hBEEF during INIT -> ready=0 for 8 cycles and 1 on the 9th; src_a=3 then reads 16'h0000 (write ignored); all 8 registers read 0.
- RUN: alloc_reg=2; next cycle src_a=2 -> busy_a=1, any_busy=1; load dest=2 in=16'h1234 -> next cycle reg_a=16'h1234, busy_a=0, any_busy=0.
- alloc_reg=5 twice without a load -> alloc_err=1 after the second edge and stays 1 through later loads; a rst_n pulse clears it.
- Same cycle load dest=4 in=16'h00AA plus alloc_reg=4, with busy[4]=1 beforehand -> data[4]=16'h00AA, busy[4]=1, alloc_err=0.
- src_a=src_b=1 with load dest=1 in=16'h5555 -> with REGFILE_BYPASS_EN both ports show 16'h5555 that cycle; without it they show the old value that cycle and 16'h5555 the next.
- Assert rst_n low mid-sweep (init_ptr=4) with busy bits set -> ready=0, busy all 0 immediately; after release, ready rises NREGS cycles later; repeat with WIDTH=32, NREGS=16 -> ready after 16 cycles, 32-bit data round-trips.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with busy scoreboard and init sweep.
// Optional write-through read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             load,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] in,
  input  logic             alloc,
  input  logic [AW-1:0]    alloc_reg,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic             any_busy,
  output logic             alloc_err
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             run;
  logic [WIDTH-1:0] mem [NREGS];

  assign run = (state_q == RUN);

  // Control state: FSM, sweep pointer, scoreboard and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next state; alloc is applied after load so a same-index alloc wins.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (load) begin
          busy_d[dest] = 1'b0;
        end
        if (alloc) begin
          if (busy_q[alloc_reg] &&
              !(load && dest == alloc_reg)) begin
            err_d = 1'b1;
          end
          busy_d[alloc_reg] = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Storage: zeroed by the sweep, written by writeback once running.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[ptr_q] <= '0;
    end else if (load) begin
      mem[dest] <= in;
    end
  end

  // Read port A; everything reads 0 until the sweep has finished.
  always_comb begin
    reg_a  = '0;
    busy_a = 1'b0;
    if (run) begin
      reg_a  = mem[src_a];
      busy_a = busy_q[src_a];
`ifdef REGFILE_BYPASS_EN
      if (load && dest == src_a) begin
        reg_a  = in;
        busy_a = alloc && (alloc_reg == src_a);
      end
`endif
    end
  end

  // Read port B, same behaviour as port A.
  always_comb begin
    reg_b  = '0;
    busy_b = 1'b0;
    if (run) begin
      reg_b  = mem[src_b];
      busy_b = busy_q[src_b];
`ifdef REGFILE_BYPASS_EN
      if (load && dest == src_b) begin
        reg_b  = in;
        busy_b = alloc && (alloc_reg == src_b);
      end
`endif
    end
  end

  assign ready     = run;
  assign any_busy  = |busy_q;
  assign alloc_err = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized + directed scoreboard bench for regfile_sb.
// Expectations come from an array model of the register file rules.
module tb_regfile_sb #(
  parameter int W = 16,
  parameter int N = 8
);
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ready;
  logic          load;
  logic [AW-1:0] dest;
  logic [W-1:0]  in;
  logic          alloc;
  logic [AW-1:0] alloc_reg;
  logic [AW-1:0] src_a;
  logic [AW-1:0] src_b;
  logic [W-1:0]  reg_a;
  logic [W-1:0]  reg_b;
  logic          busy_a;
  logic          busy_b;
  logic          any_busy;
  logic          alloc_err;

  regfile_sb #(.WIDTH(W), .NREGS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .load      (load),
    .dest      (dest),
    .in        (in),
    .alloc     (alloc),
    .alloc_reg (alloc_reg),
    .src_a     (src_a),
    .src_b     (src_b),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .any_busy  (any_busy),
    .alloc_err (alloc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ba;
    logic         bb;
    logic         any;
    logic         rdy;
    logic         err;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_data [N];
  bit           m_busy [N];
  bit           m_err;
  int           m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void chk(string nm, logic [W-1:0] act,
                              logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, req, $time);
    end
  endfunction

  function automatic void read_port(int s, output logic [W-1:0] v,
                                    output logic bz);
    v  = m_data[s];
    bz = m_busy[s];
`ifdef REGFILE_BYPASS_EN
    if (load && int'(dest) == s) begin
      v  = in;
      bz = alloc && int'(alloc_reg) == s;
    end
`endif
  endfunction

  // One cycle: drive inputs after the edge, queue expectation, advance model.
  task automatic step(bit rs, bit ld, int d, logic [W-1:0] v,
                      bit al, int ar, int sa, int sb);
    exp_t e;
    bit   run;
    @(posedge clk);
    #1;
    rst_n     = rs;
    load      = ld;
    dest      = AW'(d);
    in        = v;
    alloc     = al;
    alloc_reg = AW'(ar);
    src_a     = AW'(sa);
    src_b     = AW'(sb);
    if (!rs) m_reset();
    run = (m_cnt >= N);
    e.a = '0; e.b = '0; e.ba = 0; e.bb = 0; e.any = 0;
    e.rdy = run;
    e.err = m_err;
    if (run) begin
      read_port(sa, e.a, e.ba);
      read_port(sb, e.b, e.bb);
      for (int i = 0; i < N; i++) if (m_busy[i]) e.any = 1'b1;
    end
    q.push_back(e);
    if (rs) begin
      if (!run) begin
        m_cnt++;
      end else begin
        if (al && m_busy[ar] && !(ld && d == ar)) m_err = 1'b1;
        if (ld) begin
          m_data[d] = v;
          m_busy[d] = 1'b0;
        end
        if (al) m_busy[ar] = 1'b1;
      end
    end
  endtask

  task automatic idle(int sa, int sb);
    step(1, 0, 0, '0, 0, 0, sa, sb);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("reg_a", reg_a, e.a);
      chk("reg_b", reg_b, e.b);
      chk("busy_a", W'(busy_a), W'(e.ba));
      chk("busy_b", W'(busy_b), W'(e.bb));
      chk("any_busy", W'(any_busy), W'(e.any));
      chk("ready", W'(ready), W'(e.rdy));
      chk("alloc_err", W'(alloc_err), W'(e.err));
    end
  end

  initial begin
    int wait_cnt;
    rst_n = 0; load = 0; dest = '0; in = '0;
    alloc = 0; alloc_reg = '0; src_a = '0; src_b = '0;
    m_reset();
    step(0, 0, 0, '0, 0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0, 0);
    // Release reset; writes and allocs during the sweep are ignored.
    step(1, 1, 3 % N, W'(16'hBEEF), 1, 3 % N, 3 % N, 0);
    for (int i = 1; i < N + 1; i++) idle(3 % N, i % N);
    for (int i = 0; i < N; i++) idle(i, (N - 1) - i);
    // Alloc then load retires the busy bit.
    step(1, 0, 0, '0, 1, 2, 2, 2);
    idle(2, 0);
    step(1, 1, 2, W'(16'h1234), 0, 0, 2, 2);
    idle(2, 2);
    // Double alloc sets the sticky error.
    step(1, 0, 0, '0, 1, 5 % N, 5 % N, 0);
    step(1, 0, 0, '0, 1, 5 % N, 5 % N, 0);
    step(1, 1, 5 % N, W'(16'h0F0F), 0, 0, 5 % N, 0);
    idle(5 % N, 0);
    // Same-cycle load and alloc on a busy register: alloc wins, no error.
    step(0, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) idle(0, 0);
    step(1, 0, 0, '0, 1, 4 % N, 4 % N, 0);
    step(1, 1, 4 % N, W'(16'h00AA), 1, 4 % N, 4 % N, 4 % N);
    idle(4 % N, 4 % N);
    // Read-during-write on both ports.
    step(1, 1, 1, W'(16'h5555), 0, 0, 1, 1);
    idle(1, 1);
    // Reset mid-sweep with busy bits pending.
    step(1, 0, 0, '0, 1, 6 % N, 6 % N, 0);
    step(0, 0, 0, '0, 0, 0, 6 % N, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < N / 2; i++) idle(0, 0);
    step(0, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < N + 2; i++) idle(i % N, 0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, N - 1),
           W'({$urandom, $urandom}),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, N - 1),
           $urandom_range(0, N - 1),
           $urandom_range(0, N - 1));
    end
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
